// File: rtl/harness_pkg.sv
// rtl/harness_pkg.sv - shared states and instruction constants for the core run harness
package harness_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT,
        ST_TIMEOUT,
        ST_FAULT
    } state_t;

    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [31:0] SELF_LOOP = 32'h0000_006F;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    // Either encoding means the program has finished.
    function automatic logic is_halt_instr(input logic [31:0] word);
        return (word == EBREAK) || (word == SELF_LOOP);
    endfunction

endpackage

// File: rtl/core_test_harness_if.sv
// rtl/core_test_harness_if.sv - fetch/data bus between the harness and one single-cycle core
interface core_test_harness_if #(
    parameter int XLEN = 32
);
    logic            core_reset;
    logic [XLEN-1:0] pc;
    logic            mem_write;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] read_data;

    modport master (
        input  core_reset, instr, read_data,
        output pc, mem_write, alu_result, write_data
    );

    modport slave (
        output core_reset, instr, read_data,
        input  pc, mem_write, alu_result, write_data
    );
endinterface

// File: rtl/harness_word_mem.sv
// rtl/harness_word_mem.sv - word RAM with synchronous write and asynchronous read
module harness_word_mem #(
    parameter  int DEPTH = 256,
    parameter  int XLEN  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/core_test_harness.sv
// rtl/core_test_harness.sv - loadable imem/dmem run harness for the RV32I core; HARNESS_SIGNATURE_EN enables the store signature
module core_test_harness
    import harness_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int MAX_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                clear,
    input  logic                load_en,
    input  logic                load_sel,
    input  logic [XLEN-1:0]     load_addr,
    input  logic [XLEN-1:0]     load_data,
    core_test_harness_if.slave  bus,
    output logic                done,
    output logic                timeout,
    output logic                fault,
    output logic [31:0]         cycle_count,
    output logic [31:0]         store_count,
    output logic [XLEN-1:0]     signature
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    state_t state, state_next;

    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] dmem_rdata;
    logic [XLEN-1:0] fetch_word;

    logic pc_aligned, pc_in_range, data_in_range;
    logic load_imem_in_range, load_dmem_in_range;
    logic run_fault, run_halt, run_timeout;
    logic load_ok, store_ok;
    logic imem_we, dmem_we;
    logic [DAW-1:0]  dmem_waddr;
    logic [XLEN-1:0] dmem_wdata;

    // Byte offsets within a word carry no meaning on the data/load paths.
    logic unused_bits;
    assign unused_bits = ^{bus.alu_result[1:0], load_addr[1:0]};

    assign pc_aligned         = (bus.pc[1:0] == 2'b00);
    assign pc_in_range        = (bus.pc[XLEN-1:IAW+2] == '0);
    assign data_in_range      = (bus.alu_result[XLEN-1:DAW+2] == '0);
    assign load_imem_in_range = (load_addr[XLEN-1:IAW+2] == '0);
    assign load_dmem_in_range = (load_addr[XLEN-1:DAW+2] == '0);

    assign fetch_word    = pc_in_range   ? imem_rdata : XLEN'(NOP);
    assign bus.instr     = fetch_word;
    assign bus.read_data = data_in_range ? dmem_rdata : '0;

    assign run_fault   = !pc_aligned || !pc_in_range || (bus.mem_write && !data_in_range);
    assign run_halt    = is_halt_instr(fetch_word[31:0]);
    assign run_timeout = (cycle_count == 32'(MAX_CYCLES - 1));

    // Writes sampled on a reset edge are dropped so reset never disturbs memory.
    assign load_ok  = (state == ST_IDLE) && load_en && !reset;
    assign store_ok = (state == ST_RUN) && bus.mem_write && !run_fault && !reset;

    assign imem_we    = load_ok && !load_sel && load_imem_in_range;
    assign dmem_we    = (load_ok && load_sel && load_dmem_in_range) || store_ok;
    assign dmem_waddr = store_ok ? bus.alu_result[DAW+1:2] : load_addr[DAW+1:2];
    assign dmem_wdata = store_ok ? bus.write_data : load_data;

    harness_word_mem #(.DEPTH(IMEM_DEPTH), .XLEN(XLEN)) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (load_addr[IAW+1:2]),
        .wdata (load_data),
        .raddr (bus.pc[IAW+1:2]),
        .rdata (imem_rdata)
    );

    harness_word_mem #(.DEPTH(DMEM_DEPTH), .XLEN(XLEN)) u_dmem (
        .clk   (clk),
        .we    (dmem_we),
        .waddr (dmem_waddr),
        .wdata (dmem_wdata),
        .raddr (bus.alu_result[DAW+1:2]),
        .rdata (dmem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!clear && start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_next = ST_IDLE;
                end else if (run_fault) begin
                    state_next = ST_FAULT;
                end else if (run_halt) begin
                    state_next = ST_HALT;
                end else if (run_timeout) begin
                    state_next = ST_TIMEOUT;
                end
            end
            ST_HALT, ST_TIMEOUT, ST_FAULT: begin
                if (clear) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.core_reset = (state != ST_RUN);
    assign done           = (state == ST_HALT);
    assign timeout        = (state == ST_TIMEOUT);
    assign fault          = (state == ST_FAULT);

    // Counting stops outside RUN, which freezes them in the terminal states.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            store_count <= '0;
        end else if (state == ST_IDLE && start && !clear) begin
            cycle_count <= '0;
            store_count <= '0;
        end else if (state == ST_RUN) begin
            cycle_count <= cycle_count + 32'd1;
            if (store_ok) begin
                store_count <= store_count + 32'd1;
            end
        end
    end

`ifdef HARNESS_SIGNATURE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            signature <= '0;
        end else if (state == ST_IDLE && start && !clear) begin
            signature <= '0;
        end else if (store_ok) begin
            signature <= {signature[XLEN-2:0], signature[XLEN-1]} ^ bus.write_data ^ bus.alu_result;
        end
    end
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_core_test_harness.sv
// tb/tb_core_test_harness.sv - directed bench for core_test_harness
module tb_core_test_harness;

    logic        clk = 1'b0;
    logic        reset, start, clear, load_en, load_sel;
    logic [31:0] load_addr, load_data;
    logic        done, timeout, fault;
    logic [31:0] cycle_count, store_count, signature;

    int passed = 0;
    int total  = 0;

    core_test_harness_if #(.XLEN(32)) bus ();

    core_test_harness #(
        .XLEN(32), .IMEM_DEPTH(16), .DMEM_DEPTH(16), .MAX_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .clear       (clear),
        .load_en     (load_en),
        .load_sel    (load_sel),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .bus         (bus),
        .done        (done),
        .timeout     (timeout),
        .fault       (fault),
        .cycle_count (cycle_count),
        .store_count (store_count),
        .signature   (signature)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic load(input logic sel, input logic [31:0] addr, input logic [31:0] data);
        load_en = 1'b1; load_sel = sel; load_addr = addr; load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clear = 1'b0; load_en = 1'b0; load_sel = 1'b0;
        load_addr = '0; load_data = '0;
        bus.pc = '0; bus.mem_write = 1'b0; bus.alu_result = '0; bus.write_data = '0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("rst_core_reset", {31'd0, bus.core_reset}, 32'd1);
        check("rst_flags", {29'd0, done, timeout, fault}, 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_store_count", store_count, 32'd0);
        check("rst_signature", signature, 32'd0);

        // Scenario 1: addi / sw / ebreak
        load(1'b0, 32'd0, 32'h0040_0093);
        load(1'b0, 32'd4, 32'h0010_2423);
        load(1'b0, 32'd8, 32'h0010_0073);
        bus.pc = 32'd0; #1;
        check("idle_fetch", bus.instr, 32'h0040_0093);
        bus.pc = 32'd64; #1;
        check("oor_fetch_nop", bus.instr, 32'h0000_0013);
        bus.alu_result = 32'd64; #1;
        check("oor_read_zero", bus.read_data, 32'd0);
        bus.pc = 32'd0;
        pulse_start();
        check("run_core_reset", {31'd0, bus.core_reset}, 32'd0);
        check("run_fetch0", bus.instr, 32'h0040_0093);
        tick();
        bus.pc = 32'd4; bus.mem_write = 1'b1; bus.alu_result = 32'd8; bus.write_data = 32'd4; #1;
        check("run_fetch1", bus.instr, 32'h0010_2423);
        tick();
        bus.pc = 32'd8; bus.mem_write = 1'b0;
        tick();
        check("s1_done", {31'd0, done}, 32'd1);
        check("s1_cycle_count", cycle_count, 32'd3);
        check("s1_store_count", store_count, 32'd1);
        check("s1_core_reset", {31'd0, bus.core_reset}, 32'd1);
        check("s1_dmem2", bus.read_data, 32'd4);
`ifdef HARNESS_SIGNATURE_EN
        check("s1_signature", signature, 32'h0000_000C);
`else
        check("s1_signature", signature, 32'd0);
`endif

        // Scenario 2: self loop halts after one cycle; loads during RUN are ignored
        pulse_clear();
        check("clr_done", {31'd0, done}, 32'd0);
        load(1'b0, 32'd0, 32'h0000_006F);
        bus.pc = 32'd0;
        pulse_start();
        check("s2_sig_cleared", signature, 32'd0);
        load(1'b1, 32'd8, 32'hDEAD_BEEF);
        check("s2_done", {31'd0, done}, 32'd1);
        check("s2_cycle_count", cycle_count, 32'd1);
        check("s2_store_count", store_count, 32'd0);
        bus.alu_result = 32'd8; #1;
        check("s2_run_load_ignored", bus.read_data, 32'd4);

        // Scenario 3: two-instruction loop runs out the 16-cycle budget
        pulse_clear();
        load(1'b0, 32'd0, 32'h0000_0013);
        load(1'b0, 32'd4, 32'hFFDF_F06F);
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            bus.pc = (k % 2 == 1) ? 32'd4 : 32'd0;
            if (k == 15) begin
                #1;
                check("s3_not_yet", {31'd0, timeout}, 32'd0);
            end
            tick();
        end
        check("s3_timeout", {31'd0, timeout}, 32'd1);
        check("s3_done_low", {31'd0, done}, 32'd0);
        check("s3_cycle_count", cycle_count, 32'd16);
        tick();
        check("s3_sticky", {31'd0, timeout}, 32'd1);
        check("s3_frozen", cycle_count, 32'd16);

        // Scenario 4: jal x0,64 leaves the 16-word imem
        pulse_clear();
        load(1'b0, 32'd0, 32'h0400_006F);
        bus.pc = 32'd0;
        pulse_start();
        tick();
        check("s4_cycle1_no_fault", {31'd0, fault}, 32'd0);
        bus.pc = 32'd64;
        tick();
        check("s4_fault", {31'd0, fault}, 32'd1);
        check("s4_cycle_count", cycle_count, 32'd2);
        pulse_clear();
        check("s4_clear_flags", {29'd0, done, timeout, fault}, 32'd0);
        check("s4_clear_core_reset", {31'd0, bus.core_reset}, 32'd1);

        // Scenario 5: out-of-range store faults ahead of a halting fetch
        load(1'b0, 32'd0, 32'h0000_006F);
        bus.pc = 32'd0;
        pulse_start();
        bus.mem_write = 1'b1; bus.alu_result = 32'd64; bus.write_data = 32'd5;
        tick();
        bus.mem_write = 1'b0;
        check("s5_fault", {31'd0, fault}, 32'd1);
        check("s5_not_done", {31'd0, done}, 32'd0);
        check("s5_store_dropped", store_count, 32'd0);
        pulse_clear();

        // Scenario 6: out-of-range load is dropped instead of aliasing to word 0
        load(1'b0, 32'd64, 32'hABCD_0000);
        bus.pc = 32'd0; #1;
        check("s6_oor_load", bus.instr, 32'h0000_006F);

        // Scenario 7: reset mid-RUN drops the in-flight store
        load(1'b0, 32'd0, 32'h0000_0013);
        pulse_start();
        tick();
        bus.mem_write = 1'b1; bus.alu_result = 32'd8; bus.write_data = 32'h77; reset = 1'b1;
        tick();
        reset = 1'b0; bus.mem_write = 1'b0; #1;
        check("s7_core_reset", {31'd0, bus.core_reset}, 32'd1);
        check("s7_cycle_count", cycle_count, 32'd0);
        check("s7_store_count", store_count, 32'd0);
        check("s7_dmem2_kept", bus.read_data, 32'd4);

        // Scenario 8: start with clear stays in IDLE
        start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        check("s8_stay_idle", {31'd0, bus.core_reset}, 32'd1);
        pulse_start();
        check("s8_start_runs", {31'd0, bus.core_reset}, 32'd0);
        pulse_clear();
        check("s8_clear_run", {31'd0, bus.core_reset}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
